// File: rtl/npu8_core.sv
// NPU8 quantized arithmetic datapath: four registered stages from operand beat to result write,
// plus running max/min of the written results for the CPU interface.
module npu8_core #(
  parameter int ACC_W = 40
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SOFT_RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic        INV_ASEL,
  input  logic        INV_BSEL,
  input  logic [31:0] AD_GAIN,
  input  logic [31:0] AD_QPARAM,
  input  logic [31:0] ML1_GAIN,
  input  logic [31:0] ML1_QPARAM,
  input  logic [7:0]  REQ_MID,
  input  logic [31:0] REQ_GAIN,
  input  logic        NPU_EN,
  input  logic [7:0]  A_RDATA,
  input  logic [7:0]  B_RDATA,
  output logic        LM_EN,
  output logic [7:0]  C_WDATA,
  output logic        BUSY,
  output logic [7:0]  RMAX,
  output logic [7:0]  RMIN
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_MUL  = 2'd1,
    OP_RQT  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  localparam int P_W = 26;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);

  op_t         cfg_op;
  logic        cfg_inv_a, cfg_inv_b;
  logic [31:0] cfg_ad_gain;
  logic [28:0] cfg_ad_qparam, cfg_ml1_qparam;
  logic [15:0] cfg_ml1_gain;
  logic [7:0]  cfg_req_mid;
  logic [20:0] cfg_req_gain;

  logic unused_cfg_bits;
  assign unused_cfg_bits = &{1'b0, AD_QPARAM[31:29], ML1_QPARAM[31:29], ML1_GAIN[31:16], REQ_GAIN[31:21]};

  // The datapath only ever sees this snapshot, so the CPU may reprogram inputs mid-run.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cfg_op         <= OP_ADD;
      cfg_inv_a      <= 1'b0;
      cfg_inv_b      <= 1'b0;
      cfg_ad_gain    <= '0;
      cfg_ad_qparam  <= '0;
      cfg_ml1_gain   <= '0;
      cfg_ml1_qparam <= '0;
      cfg_req_mid    <= '0;
      cfg_req_gain   <= '0;
    end else if (START) begin
      cfg_op         <= op_t'(OP);
      cfg_inv_a      <= INV_ASEL;
      cfg_inv_b      <= INV_BSEL;
      cfg_ad_gain    <= AD_GAIN;
      cfg_ad_qparam  <= AD_QPARAM[28:0];
      cfg_ml1_gain   <= ML1_GAIN[15:0];
      cfg_ml1_qparam <= ML1_QPARAM[28:0];
      cfg_req_mid    <= REQ_MID;
      cfg_req_gain   <= REQ_GAIN[20:0];
    end
  end

  logic [28:0] qparam;
  logic [7:0]  za, zb, zc;
  logic [4:0]  sh;

  // Requantize reuses its mid point as both input and output zero point.
  always_comb begin
    qparam = (cfg_op == OP_MUL) ? cfg_ml1_qparam : cfg_ad_qparam;
    za = qparam[7:0];
    zb = qparam[15:8];
    zc = qparam[23:16];
    sh = qparam[28:24];
    if (cfg_op == OP_RQT) begin
      za = cfg_req_mid;
      zc = cfg_req_mid;
      sh = cfg_req_gain[20:16];
    end
  end

  logic signed [8:0] da_raw, db_raw;
  logic signed [8:0] da1, db1;
  logic [7:0]        a1;
  logic              v1, v2, v3;

  assign da_raw = $signed({1'b0, A_RDATA}) - $signed({1'b0, za});
  assign db_raw = $signed({1'b0, B_RDATA}) - $signed({1'b0, zb});

  always_ff @(posedge CLK) begin
    if (RESET || SOFT_RESET) v1 <= 1'b0;
    else v1 <= NPU_EN && !START;
    da1 <= cfg_inv_a ? -da_raw : da_raw;
    db1 <= cfg_inv_b ? -db_raw : db_raw;
    a1  <= A_RDATA;
  end

  logic [15:0]          ga, gb, gr, gm;
  logic signed [24:0]   prod_a, prod_b, prod_r;
  logic signed [17:0]   prod_m;
  logic signed [P_W-1:0] p_next, p2;

  assign ga = cfg_ad_gain[15:0];
  assign gb = cfg_ad_gain[31:16];
  assign gr = cfg_req_gain[15:0];
  assign gm = cfg_ml1_gain;

  assign prod_a = {{16{da1[8]}}, da1} * {{9{ga[15]}}, ga};
  assign prod_b = {{16{db1[8]}}, db1} * {{9{gb[15]}}, gb};
  assign prod_r = {{16{da1[8]}}, da1} * {{9{gr[15]}}, gr};
  assign prod_m = {{9{da1[8]}}, da1} * {{9{db1[8]}}, db1};

  always_comb begin
    case (cfg_op)
      OP_ADD:  p_next = {prod_a[24], prod_a} + {prod_b[24], prod_b};
      OP_MUL:  p_next = {{8{prod_m[17]}}, prod_m};
      OP_RQT:  p_next = {prod_r[24], prod_r};
      default: p_next = {18'd0, a1};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || SOFT_RESET) v2 <= 1'b0;
    else v2 <= v1;
    p2 <= p_next;
  end

  logic signed [ACC_W-1:0] p2_x, gm_x, acc_next, acc3;

  assign p2_x = {{(ACC_W-P_W){p2[P_W-1]}}, p2};
  assign gm_x = {{(ACC_W-16){gm[15]}}, gm};
  assign acc_next = (cfg_op == OP_MUL) ? p2_x * gm_x : p2_x;

  always_ff @(posedge CLK) begin
    if (RESET || SOFT_RESET) v3 <= 1'b0;
    else v3 <= v2;
    acc3 <= acc_next;
  end

  logic signed [ACC_W-1:0] rnd, acc_rnd, acc_sh, acc_zc;
  logic [7:0]              c_next;

  // Round half up before the arithmetic shift, then clamp to the uint8 output range.
  always_comb begin
    rnd = '0;
    if (sh != 5'd0) rnd = {{(ACC_W-1){1'b0}}, 1'b1} << (sh - 5'd1);
    acc_rnd = acc3 + rnd;
    acc_sh  = acc_rnd >>> sh;
    acc_zc  = acc_sh + $signed({{(ACC_W-8){1'b0}}, zc});
    if (cfg_op == OP_PASS) c_next = acc3[7:0];
    else if (acc_zc[ACC_W-1]) c_next = 8'h00;
    else if (acc_zc > SAT_MAX) c_next = 8'hFF;
    else c_next = acc_zc[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LM_EN   <= 1'b0;
      C_WDATA <= 8'h00;
    end else if (SOFT_RESET) begin
      LM_EN <= 1'b0;
    end else begin
      LM_EN <= v3;
      if (v3) C_WDATA <= c_next;
    end
  end

  // Statistics lag the result beat by one cycle; any clear wins over an update.
  always_ff @(posedge CLK) begin
    if (RESET || SOFT_RESET || START) begin
      RMAX <= 8'h00;
      RMIN <= 8'hFF;
    end else if (LM_EN) begin
      if (C_WDATA > RMAX) RMAX <= C_WDATA;
      if (C_WDATA < RMIN) RMIN <= C_WDATA;
    end
  end

  assign BUSY = v1 | v2 | v3 | LM_EN;

endmodule

// File: tb/tb_npu8_core.sv
// Self-checking bench for npu8_core: table of single-beat vectors plus hand-written
// throughput, statistics, soft-reset and reset sequences, all checked through a scoreboard.
module tb_npu8_core;

  logic        CLK = 1'b0;
  logic        RESET, SOFT_RESET, START;
  logic [1:0]  OP;
  logic        INV_ASEL, INV_BSEL;
  logic [31:0] AD_GAIN, AD_QPARAM, ML1_GAIN, ML1_QPARAM, REQ_GAIN;
  logic [7:0]  REQ_MID;
  logic        NPU_EN;
  logic [7:0]  A_RDATA, B_RDATA;
  logic        LM_EN, BUSY;
  logic [7:0]  C_WDATA, RMAX, RMIN;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int lm_seen = 0;

  typedef struct {
    logic [1:0]  op;
    logic        inv_a;
    logic        inv_b;
    logic [31:0] ad_gain;
    logic [31:0] ad_qparam;
    logic [31:0] ml1_gain;
    logic [31:0] ml1_qparam;
    logic [7:0]  req_mid;
    logic [31:0] req_gain;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  exp_c;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    int         at;
  } exp_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  exp_t sbq[$];

  npu8_core #(.ACC_W(40)) dut (
    .CLK(CLK), .RESET(RESET), .SOFT_RESET(SOFT_RESET), .START(START),
    .OP(OP), .INV_ASEL(INV_ASEL), .INV_BSEL(INV_BSEL),
    .AD_GAIN(AD_GAIN), .AD_QPARAM(AD_QPARAM), .ML1_GAIN(ML1_GAIN), .ML1_QPARAM(ML1_QPARAM),
    .REQ_MID(REQ_MID), .REQ_GAIN(REQ_GAIN),
    .NPU_EN(NPU_EN), .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
    .LM_EN(LM_EN), .C_WDATA(C_WDATA), .BUSY(BUSY), .RMAX(RMAX), .RMIN(RMIN)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one operand beat in the current cycle and records its result, due 4 cycles later.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_c);
    exp_t e;
    NPU_EN  = 1'b1;
    A_RDATA = a;
    B_RDATA = b;
    e.c  = exp_c;
    e.at = cyc + 4;
    sbq.push_back(e);
  endtask

  task automatic setConfig(input vec_t v);
    OP         = v.op;
    INV_ASEL   = v.inv_a;
    INV_BSEL   = v.inv_b;
    AD_GAIN    = v.ad_gain;
    AD_QPARAM  = v.ad_qparam;
    ML1_GAIN   = v.ml1_gain;
    ML1_QPARAM = v.ml1_qparam;
    REQ_MID    = v.req_mid;
    REQ_GAIN   = v.req_gain;
  endtask

  task automatic scrambleConfig();
    OP         = 2'($urandom_range(0, 3));
    INV_ASEL   = 1'($urandom_range(0, 1));
    INV_BSEL   = 1'($urandom_range(0, 1));
    AD_GAIN    = $urandom;
    AD_QPARAM  = $urandom;
    ML1_GAIN   = $urandom;
    ML1_QPARAM = $urandom;
    REQ_MID    = 8'($urandom_range(0, 255));
    REQ_GAIN   = $urandom;
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (LM_EN) begin
        lm_seen++;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_lm_en", int'(LM_EN), 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("c_wdata", int'(C_WDATA), int'(e.c));
          checkOutput("latency", cyc, e.at);
        end
      end
    end
  endtask

  task automatic waitDrain();
    int k = 0;
    @(negedge CLK);
    while ((sbq.size() != 0 || BUSY) && k < 60) begin
      @(negedge CLK);
      k++;
    end
    if (sbq.size() != 0 || BUSY) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: pending=%0d busy=%0b, required 0 and 0", sbq.size(), BUSY);
      sbq.delete();
    end
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  function automatic logic [7:0] addRef(input int a, input int b);
    int s = a + b;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  initial begin
    int t0;
    int seen0;

    vecs[0]  = '{2'd0, 1'b0, 1'b0, 32'h0100_0100, 32'h0800_0000, 32'h0, 32'h0, 8'd0, 32'h0, 8'd10, 8'd20, 8'd30};
    vecs[1]  = '{2'd0, 1'b0, 1'b0, 32'h0100_0100, 32'h0800_0000, 32'h0, 32'h0, 8'd0, 32'h0, 8'd200, 8'd100, 8'd255};
    vecs[2]  = '{2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 32'h0800_0000, 8'd0, 32'h0, 8'd32, 8'd16, 8'd2};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 32'h0880_0000, 8'd0, 32'h0, 8'd32, 8'd16, 8'd126};
    vecs[4]  = '{2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd128, 32'h0008_0200, 8'd138, 8'd0, 8'd148};
    vecs[5]  = '{2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd128, 32'h0008_0200, 8'd28, 8'd0, 8'd0};
    vecs[6]  = '{2'd3, 1'b1, 1'b1, 32'h0100_0100, 32'h0810_0505, 32'h0, 32'h0, 8'd0, 32'h0, 8'd77, 8'd9, 8'd77};
    vecs[7]  = '{2'd0, 1'b0, 1'b0, 32'hFF00_0080, 32'h0803_050A, 32'h0, 32'h0, 8'd0, 32'h0, 8'd90, 8'd15, 8'd33};
    vecs[8]  = '{2'd0, 1'b0, 1'b0, 32'h0001_0001, 32'h0000_0000, 32'h0, 32'h0, 8'd0, 32'h0, 8'd100, 8'd100, 8'd200};
    vecs[9]  = '{2'd1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0001, 32'h08C8_0000, 8'd0, 32'h0, 8'd32, 8'd16, 8'd198};
    vecs[10] = '{2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd1, 32'h001F_7FFF, 8'd255, 8'd0, 8'd1};
    vecs[11] = '{2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_7FFF, 32'h1000_0000, 8'd0, 32'h0, 8'd255, 8'd255, 8'd255};

    RESET = 1'b1; SOFT_RESET = 1'b0; START = 1'b0; NPU_EN = 1'b0;
    A_RDATA = 8'd0; B_RDATA = 8'd0;
    setConfig(vecs[0]);
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_lm_en", int'(LM_EN), 0);
    checkOutput("reset_c_wdata", int'(C_WDATA), 0);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_rmax", int'(RMAX), 0);
    checkOutput("reset_rmin", int'(RMIN), 255);
    tick();
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      tick();
      setConfig(vecs[i]);
      START = 1'b1;
      tick();
      START = 1'b0;
      scrambleConfig();
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp_c);
      tick();
      NPU_EN = 1'b0;
      waitDrain();
    end

    tick();
    setConfig(vecs[0]);
    START = 1'b1;
    tick();
    START = 1'b0;
    applyStimulus(8'd10, 8'd20, 8'd30);
    tick();
    applyStimulus(8'd200, 8'd100, 8'd255);
    tick();
    applyStimulus(8'd1, 8'd1, 8'd2);
    tick();
    NPU_EN = 1'b0;
    waitDrain();
    checkOutput("stats_rmax", int'(RMAX), 255);
    checkOutput("stats_rmin", int'(RMIN), 2);
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    @(negedge CLK);
    checkOutput("start_clear_rmax", int'(RMAX), 0);
    checkOutput("start_clear_rmin", int'(RMIN), 255);

    tick();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(i * 30), 8'(i * 7 + 3), addRef(i * 30, i * 7 + 3));
      tick();
    end
    NPU_EN = 1'b0;
    waitCycle(t0 + 11);
    checkOutput("busy_last_beat", int'(BUSY), 1);
    @(negedge CLK);
    checkOutput("busy_drop", int'(BUSY), 0);
    waitDrain();
    checkOutput("burst_rmax", int'(RMAX), 255);
    checkOutput("burst_rmin", int'(RMIN), 3);

    tick();
    START = 1'b1;
    NPU_EN = 1'b1;
    A_RDATA = 8'd10;
    B_RDATA = 8'd20;
    tick();
    START = 1'b0;
    NPU_EN = 1'b0;
    @(negedge CLK);
    checkOutput("start_drop_busy", int'(BUSY), 0);
    waitDrain();

    tick();
    applyStimulus(8'd7, 8'd8, 8'd15);
    tick();
    NPU_EN = 1'b0;
    waitDrain();
    seen0 = lm_seen;
    tick();
    NPU_EN = 1'b1;
    A_RDATA = 8'd50;
    B_RDATA = 8'd60;
    tick();
    NPU_EN = 1'b0;
    tick();
    SOFT_RESET = 1'b1;
    tick();
    SOFT_RESET = 1'b0;
    @(negedge CLK);
    checkOutput("soft_reset_busy", int'(BUSY), 0);
    checkOutput("soft_reset_rmax", int'(RMAX), 0);
    checkOutput("soft_reset_rmin", int'(RMIN), 255);
    repeat (6) @(negedge CLK);
    checkOutput("soft_reset_no_lm_en", lm_seen - seen0, 0);
    tick();
    applyStimulus(8'd10, 8'd20, 8'd30);
    tick();
    NPU_EN = 1'b0;
    waitDrain();

    tick();
    NPU_EN = 1'b1;
    A_RDATA = 8'd5;
    B_RDATA = 8'd5;
    tick();
    NPU_EN = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("reset_mid_busy", int'(BUSY), 0);
    checkOutput("reset_mid_c_wdata", int'(C_WDATA), 0);
    tick();
    applyStimulus(8'd100, 8'd50, 8'd0);
    tick();
    NPU_EN = 1'b0;
    waitDrain();

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
